multu_unit: RTL and testbench

Sequential 32×32 unsigned multiplier with HI/LO result registers, serving MULTU and MADDU. Sits in the EX stage beside the ALU and shifter. Accepts a one-cycle start from the ALU control unit, runs one shift-add iteration per clock, and reports busy/last/done so the control unit can hold the pipeline. MFHI/MFLO read `hi`/`lo` through the EX result mux.

---
 rtl/multu_unit.sv | 130 +++++++++++++
 tb/tb_multu_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multu_unit.sv
// multu_unit: sequential WIDTH x WIDTH unsigned shift-add multiplier
// with HI/LO result registers, serving MULTU (overwrite) and MADDU (accumulate).
// Ports: clk; reset (async, active-low); start/acc/a/b request;
//        wr_hi/wr_lo/wdata MTHI/MTLO writes, honoured only when
//        MULTU_HILO_WR_EN is defined (otherwise ignored);
//        busy/last/done status; hi/lo result registers.
module multu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             last,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_COMMIT
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_acc;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_last;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_commit;
  logic               w_wr_hi;
  logic               w_wr_lo;

  assign w_last = (r_state == S_RUN) &&
                  (r_cnt == CW'(WIDTH - 1));

  // Upper half plus multiplicand when the current multiplier bit is set;
  // the carry lands in bit WIDTH and shifts down with the product.
  assign w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                 (r_prod[0] ? {1'b0, r_mcand} : '0);

  // MADDU wraps modulo 2^(2*WIDTH); the carry-out is dropped.
  assign w_commit = r_acc ? ({r_hi, r_lo} + r_prod) : r_prod;

`ifdef MULTU_HILO_WR_EN
  logic w_idle_wr;
  // start wins over the strobes; strobes only land in a quiet IDLE.
  assign w_idle_wr = (r_state == S_IDLE) && !start;
  assign w_wr_hi   = w_idle_wr && wr_hi;
  assign w_wr_lo   = w_idle_wr && wr_lo;
`else
  logic w_unused;
  assign w_unused = ^{wr_hi, wr_lo};
  assign w_wr_hi  = 1'b0;
  assign w_wr_lo  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start)  w_next = S_RUN;
      S_RUN:    if (w_last) w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_acc   <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= a;
            r_prod  <= {{WIDTH{1'b0}}, b};
            r_cnt   <= '0;
            r_acc   <= acc;
          end
        end
        S_RUN: begin
          r_prod <= {w_sum, r_prod[WIDTH-1:1]};
          r_cnt  <= r_cnt + CW'(1);
        end
        S_COMMIT: begin
          {r_hi, r_lo} <= w_commit;
          r_done       <= 1'b1;
        end
        default: ;
      endcase
      if (w_wr_hi) r_hi <= wdata;
      if (w_wr_lo) r_lo <= wdata;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign last = w_last;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_multu_unit.sv
// tb_multu_unit: random + directed stimulus for multu_unit,
// scoreboard of expected HI/LO and done/last cycles checked by a monitor.
module tb_multu_unit;

  localparam int W = 32;

`ifdef MULTU_HILO_WR_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         acc   = 1'b0;
  logic         wr_hi = 1'b0;
  logic         wr_lo = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         last;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct {
    logic [63:0] res;
    int          done_cyc;
    int          last_cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] model = '0;
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  multu_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .acc   (acc),
    .a     (a),
    .b     (b),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .wdata (wdata),
    .busy  (busy),
    .last  (last),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [63:0] act,
                                logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT reports completion.
  always @(negedge clk) begin
    if (reset) begin
      if (last) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected last at cycle %0d", cyc);
        end else begin
          check("last cycle", cyc, sb[0].last_cyc);
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected done at cycle %0d", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("done cycle", cyc, mon_e.done_cyc);
          check("hilo", {hi, lo}, mon_e.res);
          check("busy at done", busy, 1'b0);
        end
      end
    end
  end

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic issue(bit ac, logic [W-1:0] x, logic [W-1:0] y);
    exp_t e;
    if (ac) model = model + 64'(x) * 64'(y);
    else    model = 64'(x) * 64'(y);
    e.res      = model;
    e.done_cyc = cyc + 34;
    e.last_cyc = cyc + 32;
    sb.push_back(e);
    start = 1'b1;
    acc   = ac;
    a     = x;
    b     = y;
    @(posedge clk); #1;
    start = 1'b0;
    acc   = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no done within 40 cycles");
    end
  endtask

  task automatic run(bit ac, logic [W-1:0] x, logic [W-1:0] y);
    issue(ac, x, y);
    wait_done();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [W-1:0] old_hi;
    logic [W-1:0] d;

    idle(3);
    check("reset busy", busy, 1'b0);
    check("reset last", last, 1'b0);
    check("reset done", done, 1'b0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    reset = 1'b1;
    idle(1);

    run(1'b0, 32'd3, 32'd5);
    check("3x5", {hi, lo}, 64'h0000_0000_0000_000F);
    run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("max x max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run(1'b0, 32'd2, 32'd3);
    run(1'b1, 32'hFFFF_FFFF, 32'd2);
    check("maddu", {hi, lo}, 64'h0000_0002_0000_0004);

    // Build HI/LO = all ones, then wrap it with 1x1.
    run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(1'b1, 32'hFFFF_FFFF, 32'd2);
    check("all ones", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    run(1'b1, 32'd1, 32'd1);
    check("maddu wrap", {hi, lo}, 64'h0);

    // start while busy is dropped.
    issue(1'b0, 32'd3, 32'd5);
    idle(9);
    check("busy mid op", busy, 1'b1);
    start = 1'b1;
    a     = 32'd7;
    b     = 32'd7;
    idle(1);
    start = 1'b0;
    wait_done();
    check("ignored start lo", lo, 32'd15);
    idle(3);
    check("busy after ignore", busy, 1'b0);

    // Asynchronous abort mid-operation.
    issue(1'b0, $urandom, $urandom);
    idle(9);
    reset = 1'b0;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort hi", hi, 32'h0);
    check("abort lo", lo, 32'h0);
    check("abort done", done, 1'b0);
    sb.delete();
    model = '0;
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    idle(40);
    check("after abort busy", busy, 1'b0);

    // MTHI/MTLO strobes.
    run(1'b0, $urandom, $urandom);
    old_hi = model[63:32];
    wr_hi = 1'b1;
    wdata = 32'h1234_5678;
    idle(1);
    wr_hi = 1'b0;
    if (WR_EN) model[63:32] = 32'h1234_5678;
    check("mthi idle", hi, WR_EN ? 32'h1234_5678 : old_hi);
    d = $urandom;
    wr_hi = 1'b1;
    wr_lo = 1'b1;
    wdata = d;
    idle(1);
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    if (WR_EN) model = {d, d};
    check("mthi+mtlo idle", {hi, lo}, model);
    // Same-cycle start beats the strobe.
    wr_hi = 1'b1;
    wdata = 32'hAAAA_5555;
    issue(1'b1, $urandom, $urandom);
    wr_hi = 1'b0;
    idle(5);
    old_hi = hi;
    wr_hi = 1'b1;
    wr_lo = 1'b1;
    wdata = 32'h1234_5678;
    idle(1);
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    check("mthi busy", hi, old_hi);
    wait_done();

    // Random MULTU/MADDU mix, including back-to-back issue.
    for (int i = 0; i < 40; i++) begin
      idle($urandom_range(0, 3));
      run(1'($urandom), $urandom, $urandom);
    end

    idle(5);
    check("scoreboard drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
